vmem_fill: RTL and testbench

Rectangle fill engine that writes solid-colour blocks into the video memory's write port. It sits directly upstream of `vmem`. It takes one fill command at a time over a valid/ready handshake, clips the command to the 640x480 visible area, and walks the rectangle in raster order. It emits one pixel write per cycle, addressed in the same `h_addr`/`v_addr` space the VGA scan-out reads.

---
 rtl/vmem_fill.sv | 167 ++++++++++++++++
 tb/tb_vmem_fill.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_fill.sv
// vmem_fill: rectangle fill engine feeding the vmem write port.
// Accepts one fill command at a time, clips it to the visible area and
// emits one pixel write per cycle in raster order, holding on wr_stall.
module vmem_fill #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COLOR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [9:0]         cmd_x,
    input  logic [8:0]         cmd_y,
    input  logic [9:0]         cmd_w,
    input  logic [8:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               wr_stall,
    output logic               wr_en,
    output logic [9:0]         wr_h_addr,
    output logic [8:0]         wr_v_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        CLIP,
        FILL,
        DONE
    } state_t;

    localparam logic [10:0] X_LIM = 11'(H_RES);
    localparam logic [9:0]  Y_LIM = 10'(V_RES);

    state_t state;
    state_t state_next;

    logic [9:0]         x_q;
    logic [8:0]         y_q;
    logic [9:0]         w_q;
    logic [8:0]         h_q;
    logic [COLOR_W-1:0] color_q;
    logic [10:0]        x_end;
    logic [9:0]         y_end;
    logic [9:0]         cur_x;
    logic [8:0]         cur_y;

    logic [10:0] sum_x;
    logic [9:0]  sum_y;
    logic [10:0] clip_x_end;
    logic [9:0]  clip_y_end;
    logic        degenerate;
    logic [9:0]  next_x;
    logic [8:0]  next_y;
    logic        row_last;
    logic        rect_last;

    // Clip arithmetic is done one bit wider than the inputs so x+w and
    // y+h can never wrap; the pixel cursor never exceeds the clipped end.
    always_comb begin
        sum_x      = {1'b0, x_q} + {1'b0, w_q};
        sum_y      = {1'b0, y_q} + {1'b0, h_q};
        clip_x_end = (sum_x > X_LIM) ? X_LIM : sum_x;
        clip_y_end = (sum_y > Y_LIM) ? Y_LIM : sum_y;
        degenerate = (w_q == 10'd0) || (h_q == 9'd0) ||
                     ({1'b0, x_q} >= X_LIM) || ({1'b0, y_q} >= Y_LIM);
        next_x     = cur_x + 10'd1;
        next_y     = cur_y + 9'd1;
        row_last   = ({1'b0, next_x} == x_end);
        rect_last  = row_last && ({1'b0, next_y} == y_end);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status outputs decoded from the current state.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = CLIP;
                end
            end
            CLIP: begin
                state_next = degenerate ? DONE : FILL;
            end
            FILL: begin
                wr_en = !wr_stall;
                if (!wr_stall && rect_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, clip results and the raster cursor; everything holds on stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            x_end   <= '0;
            y_end   <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                    end
                end
                CLIP: begin
                    x_end <= clip_x_end;
                    y_end <= clip_y_end;
                    cur_x <= x_q;
                    cur_y <= y_q;
                end
                FILL: begin
                    if (!wr_stall) begin
                        if (row_last) begin
                            cur_x <= x_q;
                            cur_y <= next_y;
                        end else begin
                            cur_x <= next_x;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wr_h_addr = cur_x;
    assign wr_v_addr = cur_y;
    assign wr_data   = color_q;

endmodule

// File: tb/tb_vmem_fill.sv
// tb_vmem_fill: directed and randomized checks of the rectangle fill engine
// against a pixel-list model built from the clipping rules.
module tb_vmem_fill;

    localparam int HR = 640;
    localparam int VR = 480;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [23:0] cmd_color;
    logic        wr_stall;
    logic        wr_en;
    logic [9:0]  wr_h_addr;
    logic [8:0]  wr_v_addr;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    vmem_fill #(.H_RES(HR), .V_RES(VR), .COLOR_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_h_addr (wr_h_addr),
        .wr_v_addr (wr_v_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_cmd_fields();
        cmd_x     = 10'($urandom);
        cmd_y     = 9'($urandom);
        cmd_w     = 10'($urandom);
        cmd_h     = 9'($urandom);
        cmd_color = 24'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_wr_en"}, 32'(wr_en),     32'd0);
        check({tag, "_haddr"}, 32'(wr_h_addr), 32'd0);
        check({tag, "_vaddr"}, 32'(wr_v_addr), 32'd0);
        check({tag, "_data"},  32'(wr_data),   32'd0);
    endtask

    // Issues one command and follows it cycle by cycle until its done pulse.
    // latency is the cycle of done relative to the accepting edge (-1 if none).
    task automatic run_fill(input int x, input int y, input int w, input int h,
                            input logic [23:0] color, input int stall_pct,
                            input logic [31:0] stall_mask, input bit keep_valid,
                            input int rst_after, output int latency);
        int  qx[$];
        int  qy[$];
        int  xe, ye, p, rel, k, stalls, writes, f0;
        bit  finished;
        bit  st;

        xe = (x + w > HR) ? HR : x + w;
        ye = (y + h > VR) ? VR : y + h;
        if (!(w == 0 || h == 0 || x >= HR || y >= VR)) begin
            for (int r = y; r < ye; r++) begin
                for (int c = x; c < xe; c++) begin
                    qx.push_back(c);
                    qy.push_back(r);
                end
            end
        end
        p = qx.size();
        latency = -1;

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_x     = 10'(x);
        cmd_y     = 9'(y);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_color = color;
        wr_stall  = 1'($urandom);
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy",  32'(busy),      32'd0);

        @(posedge clk); #1;
        rel = 1;
        cmd_valid = keep_valid;
        randomize_cmd_fields();
        wr_stall = 1'($urandom);
        @(negedge clk);
        check("clip_wr_en", 32'(wr_en),     32'd0);
        check("clip_busy",  32'(busy),      32'd1);
        check("clip_ready", 32'(cmd_ready), 32'd0);
        check("clip_done",  32'(done),      32'd0);

        k = 0;
        stalls = 0;
        writes = 0;
        finished = 1'b0;
        while (!finished && rel < 4 * p + 60) begin
            @(posedge clk); #1;
            rel++;
            st = ((k < 32) && stall_mask[k]) || (int'($urandom_range(99)) < stall_pct);
            wr_stall = st;
            if (keep_valid) randomize_cmd_fields();
            @(negedge clk);
            f0 = failures;
            if (qx.size() > 0) begin
                check("fill_wr_en", 32'(wr_en),     32'(!st));
                check("fill_haddr", 32'(wr_h_addr), 32'(qx[0]));
                check("fill_vaddr", 32'(wr_v_addr), 32'(qy[0]));
                check("fill_data",  32'(wr_data),   32'(color));
                check("fill_done",  32'(done),      32'd0);
                k++;
                if (st) begin
                    stalls++;
                end else begin
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    writes++;
                    if (writes == rst_after) begin
                        rst = 1'b0;
                        @(posedge clk); #1;
                        rst = 1'b1;
                        wr_stall = 1'b0;
                        @(negedge clk);
                        check_reset_outputs("midrst");
                        @(posedge clk); #1;
                        @(negedge clk);
                        check("midrst_no_done", 32'(done), 32'd0);
                        check("midrst_idle",    32'(busy), 32'd0);
                        finished = 1'b1;
                    end
                end
            end else begin
                check("done_pulse", 32'(done),  32'd1);
                check("done_wr_en", 32'(wr_en), 32'd0);
                check("done_busy",  32'(busy),  32'd1);
                latency = rel;
                check("done_latency", 32'(rel), 32'(p + 2 + stalls));
                finished = 1'b1;
            end
            if (failures != f0) finished = 1'b1;
        end
        if (!finished) begin
            check("done_timeout", 32'(rel), 32'(p + 2 + stalls));
        end
        wr_stall = 1'b0;
    endtask

    int lat;
    int lat2;
    int rx, ry, rw, rh;

    // Directed scenarios followed by randomized commands.
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        wr_stall  = 1'b0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        run_fill(10, 20, 3, 2, 24'hFF0000, 0, 32'h0, 1'b0, -1, lat);
        check("basic_latency", 32'(lat), 32'd8);

        run_fill(638, 479, 5, 4, 24'h00FF00, 0, 32'h0, 1'b0, -1, lat);
        check("corner_latency", 32'(lat), 32'd4);

        run_fill(100, 100, 0, 5, 24'h123456, 0, 32'h0, 1'b0, -1, lat);
        check("w0_latency", 32'(lat), 32'd2);
        run_fill(700, 10, 5, 5, 24'h654321, 0, 32'h0, 1'b0, -1, lat);
        check("x700_latency", 32'(lat), 32'd2);
        run_fill(50, 500, 5, 5, 24'hABCDEF, 0, 32'h0, 1'b0, -1, lat);
        check("y500_latency", 32'(lat), 32'd2);

        run_fill(0, 0, 4, 1, 24'h0000FF, 0, 32'hE, 1'b0, -1, lat);
        check("stall_latency", 32'(lat), 32'd9);

        run_fill(5, 5, 1, 1, 24'h111111, 0, 32'h0, 1'b1, -1, lat);
        run_fill(6, 6, 1, 1, 24'h222222, 0, 32'h0, 1'b0, -1, lat2);
        check("b2b_first_latency", 32'(lat), 32'd3);
        check("b2b_done_spacing", 32'(1 + lat2), 32'd4);

        run_fill(100, 100, 10, 10, 24'hC0FFEE, 0, 32'h0, 1'b0, 5, lat);

        for (int i = 0; i < 24; i++) begin
            rx = (i % 2 == 0) ? int'($urandom_range(630, 700)) : int'($urandom_range(0, 620));
            ry = (i % 3 == 0) ? int'($urandom_range(470, 511)) : int'($urandom_range(0, 460));
            rw = int'($urandom_range(0, 12));
            rh = int'($urandom_range(0, 6));
            run_fill(rx, ry, rw, rh, 24'($urandom), 30, 32'h0, 1'(i % 4 == 1), -1, lat);
        end

        @(posedge clk); #1;
        @(negedge clk);
        check("final_idle_ready", 32'(cmd_ready), 32'd1);
        check("final_idle_busy",  32'(busy),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
